// File: rtl/stopwatch_counter.sv
`default_nettype none
//============================================================================
// Module   : stopwatch_counter
// Brief    : Divides clk to a TICK_HZ tick and keeps a BCD SS.hh time that
//            clears on init_regs and advances on count_enabled. The lap-hold
//            display freeze is built only when STOPWATCH_LAP_HOLD_EN is defined.
// Revision : 1.0 - initial release
//============================================================================
module stopwatch_counter #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_regs,
    input  logic        count_enabled,
    input  logic        lap,
    output logic [15:0] disp_digits,
    output logic        tick,
    output logic        wrap,
    output logic        holding
);

    localparam int                 c_DIV      = CLK_FREQ_HZ / TICK_HZ;
    localparam int                 c_PRE_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(c_DIV - 1);

    logic [c_PRE_W-1:0] r_pre;
    logic [15:0]        r_time;
    logic               r_tick;
    logic               r_wrap;
    logic               w_pre_last;
    logic [15:0]        w_time_inc;
    logic [4:0]         w_carry;

    assign w_pre_last = (r_pre == c_PRE_LAST);
    assign w_carry[0] = 1'b1;

    // BCD ripple increment: each digit advances only when every lower digit is 9.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] w_cur;
            logic       w_nine;
            assign w_cur                  = r_time[4*gi +: 4];
            assign w_nine                 = (w_cur == 4'd9);
            assign w_carry[gi+1]          = w_carry[gi] & w_nine;
            assign w_time_inc[4*gi +: 4]  = !w_carry[gi] ? w_cur :
                                            (w_nine ? 4'd0 : w_cur + 4'd1);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pre  <= '0;
            r_time <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (init_regs) begin
            r_pre  <= '0;
            r_time <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            // Paused cycles leave r_pre untouched so the fraction survives resume.
            if (count_enabled) begin
                if (w_pre_last) begin
                    r_pre  <= '0;
                    r_time <= w_time_inc;
                    r_tick <= 1'b1;
                    r_wrap <= w_carry[4];
                end else begin
                    r_pre <= r_pre + c_PRE_W'(1);
                end
            end
        end
    end

    assign tick = r_tick;
    assign wrap = r_wrap;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        r_holding;
    logic [15:0] r_lap_time;

    // Capture uses the current register, so a lap on an increment edge keeps the old value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_holding  <= 1'b0;
            r_lap_time <= '0;
        end else if (init_regs) begin
            r_holding  <= 1'b0;
        end else if (lap) begin
            if (!r_holding) begin
                r_lap_time <= r_time;
            end
            r_holding <= !r_holding;
        end
    end

    assign disp_digits = r_holding ? r_lap_time : r_time;
    assign holding     = r_holding;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign disp_digits  = r_time;
    assign holding      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : tb_stopwatch_counter
// Brief    : Randomised and directed bench for stopwatch_counter at DIV=10,
//            plus a DIV=2 instance that reaches the 99.99 wrap quickly.
// Revision : 1.0 - initial release
//============================================================================
module tb_stopwatch_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init_regs = 1'b0;
    logic        count_enabled = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] disp_a, disp_b;
    logic        tick_a, tick_b, wrap_a, wrap_b, hold_a, hold_b;

    stopwatch_counter #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) u_dut (
        .clk(clk), .reset(reset), .init_regs(init_regs), .count_enabled(count_enabled),
        .lap(lap), .disp_digits(disp_a), .tick(tick_a), .wrap(wrap_a), .holding(hold_a)
    );

    stopwatch_counter #(.CLK_FREQ_HZ(200), .TICK_HZ(100)) u_dut_fast (
        .clk(clk), .reset(reset), .init_regs(init_regs), .count_enabled(count_enabled),
        .lap(lap), .disp_digits(disp_b), .tick(tick_b), .wrap(wrap_b), .holding(hold_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: elapsed hundredths as a plain integer, per instance.
    int m_cnt [2];
    int m_pre [2];
    int m_lapv[2];
    bit m_tick[2];
    bit m_wrap[2];
    bit m_hold[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [31:0] exp_vec(input int i);
        return {13'b0, to_bcd(m_hold[i] ? m_lapv[i] : m_cnt[i]), m_tick[i], m_wrap[i], m_hold[i]};
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int div;
            div = (i == 0) ? 10 : 2;
            if (!reset || init_regs) begin
                m_cnt[i]  = 0;
                m_pre[i]  = 0;
                m_tick[i] = 0;
                m_wrap[i] = 0;
                m_hold[i] = 0;
            end else begin
`ifdef STOPWATCH_LAP_HOLD_EN
                if (lap) begin
                    if (!m_hold[i]) m_lapv[i] = m_cnt[i];
                    m_hold[i] = !m_hold[i];
                end
`endif
                m_tick[i] = 0;
                m_wrap[i] = 0;
                if (count_enabled) begin
                    if (m_pre[i] == div - 1) begin
                        m_pre[i]  = 0;
                        m_cnt[i]  = (m_cnt[i] + 1) % 10000;
                        m_tick[i] = 1;
                        m_wrap[i] = (m_cnt[i] == 0);
                    end else begin
                        m_pre[i]++;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic i, input logic e, input logic l);
        reset         = r;
        init_regs     = i;
        count_enabled = e;
        lap           = l;
        @(posedge clk);
        model_step();
        #1;
        check("model_div10", {13'b0, disp_a, tick_a, wrap_a, hold_a}, exp_vec(0));
        check("model_div2",  {13'b0, disp_b, tick_b, wrap_b, hold_b}, exp_vec(1));
    endtask

    initial begin
        int n;
        int ticks;
        bit saw_1000;
        bit saw_wrap;
        logic [15:0] disp_at_wrap;

        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_lapv[i] = 0;
            m_tick[i] = 0; m_wrap[i] = 0; m_hold[i] = 0;
        end

        // Reset with enable held high
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("reset_disp", 32'(disp_a), 32'h0);
        check("reset_tick", 32'(tick_a), 32'h0);
        check("reset_wrap", 32'(wrap_a), 32'h0);
        check("reset_hold", 32'(hold_a), 32'h0);

        // Basic count: 100 edges -> 10 ticks, 00.10
        ticks = 0;
        for (int k = 0; k < 100; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            if (tick_a) ticks++;
        end
        check("basic_ticks", 32'(ticks), 32'd10);
        check("basic_disp", 32'(disp_a), 32'h0010);

        // Pause and resume keeps the fractional prescaler count
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (15) step(1'b1, 1'b0, 1'b1, 1'b0);
        check("pause_start", 32'(disp_a), 32'h0001);
        repeat (50) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("pause_hold", 32'(disp_a), 32'h0001);
        n = 0;
        do begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            n++;
        end while (!tick_a && n < 20);
        check("resume_latency", 32'(n), 32'd5);
        check("resume_disp", 32'(disp_a), 32'h0002);

        // Count to 12.34 (passes 09.99 -> 10.00), then clear with enable high
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (12340) step(1'b1, 1'b0, 1'b1, 1'b0);
        check("count_1234", 32'(disp_a), 32'h1234);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("clear_disp", 32'(disp_a), 32'h0000);
        check("clear_tick", 32'(tick_a), 32'h0);
        n = 0;
        do begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            n++;
        end while (!tick_a && n < 30);
        check("clear_first_tick", 32'(n), 32'd10);

        // Lap hold at 00.05 while live count reaches 00.09
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (50) step(1'b1, 1'b0, 1'b1, 1'b0);
        check("lap_pre", 32'(disp_a), 32'h0005);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (39) step(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef STOPWATCH_LAP_HOLD_EN
        check("lap_frozen", 32'(disp_a), 32'h0005);
        check("lap_holding", 32'(hold_a), 32'h1);
`else
        check("lap_live", 32'(disp_a), 32'h0009);
        check("lap_holding", 32'(hold_a), 32'h0);
`endif
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("lap_release", 32'(disp_a), 32'h0009);
        check("lap_release_hold", 32'(hold_a), 32'h0);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 200) != 0, ($urandom % 100) == 0,
                 ($urandom % 8) != 0, ($urandom % 20) == 0);
        end

        // Wrap on the DIV=2 instance
        step(1'b1, 1'b1, 1'b0, 1'b0);
        saw_1000 = 0;
        saw_wrap = 0;
        disp_at_wrap = 16'hFFFF;
        for (int k = 0; k < 20010; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            if (tick_b && disp_b == 16'h1000) saw_1000 = 1;
            if (tick_b && wrap_b && !saw_wrap) begin
                saw_wrap = 1;
                disp_at_wrap = disp_b;
            end
        end
        check("carry_0999", 32'(saw_1000), 32'h1);
        check("wrap_seen", 32'(saw_wrap), 32'h1);
        check("wrap_disp", 32'(disp_at_wrap), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
